// File: rtl/apu_reg_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : apu_reg_sequencer                                             |
// | Purpose  : Turns two-byte UART commands (data byte, then address byte)   |
// |            into 8-bit APU register writes. Writes are queued in a small  |
// |            FIFO and issued over a valid/ready port. Malformed and stale  |
// |            pairs are flagged and counted.                                |
// | Ports    : clk, rst_n (sync, active-low)                                 |
// |            rx_data/rx_valid      - byte stream from the UART receiver    |
// |            reg_wr/reg_ready      - write handshake toward the APU        |
// |            reg_addr/reg_data     - head-of-queue register write          |
// |            err/err_count         - error pulse and saturating count      |
// |            fifo_full             - queue holds DEPTH entries             |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module apu_reg_sequencer #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 4096
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  input  logic       reg_ready,
  output logic       reg_wr,
  output logic [4:0] reg_addr,
  output logic [7:0] reg_data,
  output logic       err,
  output logic [7:0] err_count,
  output logic       fifo_full
);

  localparam int c_PW = $clog2(DEPTH);
  localparam int c_TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [c_TW-1:0] c_TMAX = c_TW'(TIMEOUT - 1);
  localparam logic [c_PW:0]   c_FULL = (c_PW + 1)'(DEPTH);

  typedef enum logic [0:0] {
    S_WAIT_DATA = 1'b0,
    S_WAIT_ADDR = 1'b1
  } state_t;

  state_t          r_state;
  logic [6:0]      r_held;
  logic [c_TW-1:0] r_timer;

  logic [12:0]     r_mem [DEPTH];
  logic [c_PW-1:0] r_wr_ptr;
  logic [c_PW-1:0] r_rd_ptr;
  logic [c_PW:0]   r_count;
  logic            r_fifo_full;
  logic [4:0]      r_reg_addr;
  logic [7:0]      r_reg_data;
  logic            r_err;
  logic [7:0]      r_err_count;

  logic            w_pair;
  logic            w_timeout;
  logic            w_parse_err;
  logic            w_full;
  logic            w_pop;
  logic            w_push;
  logic            w_ovf;
  logic [12:0]     w_push_word;
  logic [c_PW-1:0] w_rd_next;
  logic [c_PW:0]   w_after_pop;
  logic [c_PW:0]   w_count_next;
  logic [12:0]     w_head_next;

  // Address byte with reserved bit clear completes the pair held in WAIT_ADDR.
  assign w_pair      = rx_valid & (r_state == S_WAIT_ADDR) & rx_data[7] & ~rx_data[6];
  assign w_push_word = {rx_data[5:1], rx_data[0], r_held};
  // A byte arriving on the expiry cycle wins over the timeout.
  assign w_timeout   = (r_state == S_WAIT_ADDR) & ~rx_valid & (r_timer == c_TMAX);
  assign w_parse_err = w_timeout |
                       (rx_valid & (r_state == S_WAIT_DATA) & rx_data[7]) |
                       (rx_valid & (r_state == S_WAIT_ADDR) & ~(rx_data[7] & ~rx_data[6]));

  assign w_full       = (r_count == c_FULL);
  assign w_pop        = reg_wr & reg_ready;
  // A pop in the same cycle frees the slot, so a full queue can still accept.
  assign w_push       = w_pair & (~w_full | w_pop);
  assign w_ovf        = w_pair & w_full & ~w_pop;
  assign w_rd_next    = r_rd_ptr + c_PW'(w_pop);
  assign w_after_pop  = r_count - (c_PW + 1)'(w_pop);
  assign w_count_next = w_after_pop + (c_PW + 1)'(w_push);

  // Registered head: holds the last value when the queue drains, and
  // bypasses the incoming word when it lands in an otherwise empty queue.
  always_comb begin
    w_head_next = {r_reg_addr, r_reg_data};
    if (w_after_pop != '0) begin
      w_head_next = r_mem[w_rd_next];
    end else if (w_push) begin
      w_head_next = w_push_word;
    end
  end

  // Parser FSM
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_WAIT_DATA;
      r_held  <= '0;
      r_timer <= '0;
    end else if (rx_valid) begin
      if (!rx_data[7]) begin
        // Data byte: starts a pair, or replaces held data (flagged as error).
        r_held  <= rx_data[6:0];
        r_timer <= '0;
        r_state <= S_WAIT_ADDR;
      end else begin
        r_state <= S_WAIT_DATA;
      end
    end else if (r_state == S_WAIT_ADDR) begin
      if (r_timer == c_TMAX) begin
        r_state <= S_WAIT_DATA;
        r_held  <= '0;
      end else begin
        r_timer <= r_timer + c_TW'(1);
      end
    end
  end

  // Queue storage needs no reset; pointers and count define validity.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= w_push_word;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_fifo_full <= 1'b0;
      r_reg_addr  <= '0;
      r_reg_data  <= '0;
      r_err       <= 1'b0;
      r_err_count <= '0;
    end else begin
      r_wr_ptr    <= r_wr_ptr + c_PW'(w_push);
      r_rd_ptr    <= w_rd_next;
      r_count     <= w_count_next;
      r_fifo_full <= (w_count_next == c_FULL);
      r_reg_addr  <= w_head_next[12:8];
      r_reg_data  <= w_head_next[7:0];
      r_err       <= w_parse_err | w_ovf;
      if ((w_parse_err | w_ovf) && (r_err_count != 8'hFF)) begin
        r_err_count <= r_err_count + 8'd1;
      end
    end
  end

  assign reg_wr    = (r_count != '0);
  assign reg_addr  = r_reg_addr;
  assign reg_data  = r_reg_data;
  assign err       = r_err;
  assign err_count = r_err_count;
  assign fifo_full = r_fifo_full;

endmodule
`default_nettype wire

// File: tb/tb_apu_reg_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_apu_reg_sequencer                                          |
// | Purpose  : Scoreboard bench for apu_reg_sequencer. Expected writes are   |
// |            queued as command pairs are sent and popped on each transfer. |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_apu_reg_sequencer;

  localparam int c_DEPTH   = 4;
  localparam int c_TIMEOUT = 16;

  logic       clk;
  logic       rst_n;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       reg_ready;
  logic       reg_wr;
  logic [4:0] reg_addr;
  logic [7:0] reg_data;
  logic       err;
  logic [7:0] err_count;
  logic       fifo_full;

  apu_reg_sequencer #(
    .DEPTH   (c_DEPTH),
    .TIMEOUT (c_TIMEOUT)
  ) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .reg_ready (reg_ready),
    .reg_wr    (reg_wr),
    .reg_addr  (reg_addr),
    .reg_data  (reg_data),
    .err       (err),
    .err_count (err_count),
    .fifo_full (fifo_full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          err_seen = 0;
  int          exp_cnt = 0;
  logic [12:0] sb_q[$];

  logic        prev_stall = 1'b0;
  logic [4:0]  prev_addr  = '0;
  logic [7:0]  prev_data  = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic expect_wr(input logic [4:0] a, input logic [7:0] d);
    sb_q.push_back({a, d});
  endtask

  // Let pending err pulses land, then check pulses and the running count.
  task automatic settle(input string tag, input int e0, input int n_new);
    idle(3);
    chk({tag, "_err_pulses"}, 32'(err_seen - e0), 32'(n_new));
    exp_cnt = (exp_cnt + n_new > 255) ? 255 : exp_cnt + n_new;
    chk({tag, "_err_count"}, 32'(err_count), 32'(exp_cnt));
    chk({tag, "_sb_empty"}, 32'(sb_q.size()), 32'd0);
  endtask

  // Transfer monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      if (err) err_seen++;
      if (prev_stall && reg_wr) begin
        chk("stall_addr", 32'(reg_addr), 32'(prev_addr));
        chk("stall_data", 32'(reg_data), 32'(prev_data));
      end
      if (reg_wr && reg_ready) begin
        chk("sb_has_entry", 32'(sb_q.size() != 0), 32'd1);
        if (sb_q.size() != 0) begin
          logic [12:0] e;
          e = sb_q.pop_front();
          chk("wr_addr", 32'(reg_addr), 32'(e[12:8]));
          chk("wr_data", 32'(reg_data), 32'(e[7:0]));
        end
      end
      prev_stall = reg_wr && !reg_ready;
      prev_addr  = reg_addr;
      prev_data  = reg_data;
    end else begin
      prev_stall = 1'b0;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int e0;
    rst_n     = 1'b0;
    rx_valid  = 1'b0;
    rx_data   = 8'h00;
    reg_ready = 1'b1;
    idle(2);
    chk("rst_reg_wr",    32'(reg_wr),    32'd0);
    chk("rst_reg_addr",  32'(reg_addr),  32'd0);
    chk("rst_reg_data",  32'(reg_data),  32'd0);
    chk("rst_err",       32'(err),       32'd0);
    chk("rst_err_count", 32'(err_count), 32'd0);
    chk("rst_fifo_full", 32'(fifo_full), 32'd0);
    rst_n = 1'b1;
    idle(2);

    // Basic in-order writes, single-cycle latency into an empty queue.
    e0 = err_seen;
    send_byte(8'h27); expect_wr(5'd1, 8'hA7); send_byte(8'h83);
    chk("latency_reg_wr", 32'(reg_wr), 32'd1);
    send_byte(8'h02); expect_wr(5'd0, 8'h82); send_byte(8'h81);
    send_byte(8'h7C); expect_wr(5'd2, 8'h7C); send_byte(8'h84);
    send_byte(8'h09); expect_wr(5'd3, 8'h09); send_byte(8'h86);
    settle("basic", e0, 0);

    // Fill while stalled, overflow the fifth pair, then drain.
    e0 = err_seen;
    reg_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      send_byte(8'(8'h10 + i));
      if (i < 4) expect_wr(5'(i), 8'(8'h10 + i));
      send_byte(8'(8'h80 | (i << 1)));
      if (i == 2) chk("full_after_3", 32'(fifo_full), 32'd0);
      if (i == 3) chk("full_after_4", 32'(fifo_full), 32'd1);
    end
    idle(2);
    chk("full_after_ovf", 32'(fifo_full), 32'd1);
    chk("stalled_reg_wr", 32'(reg_wr), 32'd1);
    reg_ready = 1'b1;
    idle(4);
    chk("drained_reg_wr", 32'(reg_wr), 32'd0);
    chk("drained_full",   32'(fifo_full), 32'd0);
    chk("hold_addr", 32'(reg_addr), 32'd3);
    chk("hold_data", 32'(reg_data), 32'h13);
    settle("overflow", e0, 1);

    // Orphan address.
    e0 = err_seen;
    send_byte(8'h83);
    settle("orphan", e0, 1);

    // Data replaced by newer data.
    e0 = err_seen;
    send_byte(8'h13); send_byte(8'h1E); expect_wr(5'd0, 8'h9E); send_byte(8'h81);
    settle("replace", e0, 1);

    // Address on the exact expiry cycle is still accepted.
    e0 = err_seen;
    send_byte(8'h4B); idle(c_TIMEOUT - 1); expect_wr(5'd1, 8'hCB); send_byte(8'h83);
    settle("edge_timeout", e0, 0);

    // Timeout then orphan address.
    e0 = err_seen;
    send_byte(8'h4B); idle(c_TIMEOUT); send_byte(8'h83);
    settle("timeout", e0, 2);

    // Reserved bit set in address byte.
    e0 = err_seen;
    send_byte(8'h4B); send_byte(8'hC3);
    settle("reserved", e0, 1);

    // Reset while a write is stalled at the port: nothing issues later.
    reg_ready = 1'b0;
    send_byte(8'h05); send_byte(8'h82);
    chk("pre_rst_reg_wr", 32'(reg_wr), 32'd1);
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    exp_cnt = 0;
    reg_ready = 1'b1;
    chk("post_rst_reg_wr", 32'(reg_wr), 32'd0);
    chk("post_rst_count",  32'(err_count), 32'd0);
    idle(3);

    // Reset mid-pair: trailing address becomes an orphan.
    send_byte(8'h3A);
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    e0 = err_seen;
    send_byte(8'h84);
    for (int i = 0; i < 3; i++) begin
      chk("midpair_reg_wr", 32'(reg_wr), 32'd0);
      tick();
    end
    settle("midpair_rst", e0, 1);

    // Saturation.
    e0 = err_seen;
    for (int i = 0; i < 300; i++) send_byte(8'h80);
    settle("saturate", e0, 300);
    chk("sat_value", 32'(err_count), 32'd255);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
